// File: rtl/mcycle_unit_pkg.sv
// mcycle_unit_pkg: shared op encodings, FSM states and sizing helpers for the multiply/divide sequencer
package mcycle_unit_pkg;
    localparam int MC_WIDTH = 32;
    typedef enum logic [2:0] {
        MC_MUL    = 3'b000,
        MC_MULH   = 3'b001,
        MC_MULHSU = 3'b010,
        MC_MULHU  = 3'b011,
        MC_DIV    = 3'b100,
        MC_DIVU   = 3'b101,
        MC_REM    = 3'b110,
        MC_REMU   = 3'b111
    } mc_op_e;
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COMPUTE = 2'd1,
        ST_DONE    = 2'd2
    } state_e;
    function automatic int cnt_w(input int w);
        return $clog2(w);
    endfunction
endpackage

// File: rtl/mcycle_unit_if.sv
// mcycle_unit_if: request/response bundle between the execute stage and the multiply/divide sequencer
interface mcycle_unit_if #(parameter int WIDTH = 32);
    logic             start;
    logic [2:0]       op;
    logic [WIDTH-1:0] operand1;
    logic [WIDTH-1:0] operand2;
    logic [WIDTH-1:0] result;
    logic             busy;
    logic             done;
    modport master (output start, op, operand1, operand2, input result, busy, done);
    modport slave (input start, op, operand1, operand2, output result, busy, done);
endinterface

// File: rtl/mcycle_addsub.sv
// mcycle_addsub: adder/subtractor with carry-out, shared by multiply accumulate and divide trial subtract
module mcycle_addsub #(parameter int W = 33) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         sub,
    output logic [W-1:0] sum,
    output logic         cout
);
    assign {cout, sum} = {1'b0, a} + {1'b0, sub ? ~b : b} + {{W{1'b0}}, sub};
endmodule

// File: rtl/mcycle_unit.sv
// mcycle_unit: iterative RV32M multiply/divide sequencer, one shift-add/shift-subtract step per cycle
module mcycle_unit
    import mcycle_unit_pkg::*;
#(
    parameter int WIDTH = MC_WIDTH
) (
    input logic          clk,
    input logic          rst,
    mcycle_unit_if.slave bus
);
    localparam int CW = cnt_w(WIDTH);
    state_e               state, state_n;
    mc_op_e               op_q;
    logic [CW-1:0]        cnt;
    logic                 s1, s2, dz, accept, last, is_div, sg1, sg2, as_cout;
    logic [WIDTH:0]       hi, hi_n, as_a, as_b, as_sum, mul_t;
    logic [WIDTH-1:0]     lo, lo_n, opb, orig1, result_q, m1, m2, quo, remd, res_n;
    logic [2*WIDTH-1:0]   prod, prod_f;
    always_comb begin
        accept     = (state != ST_COMPUTE) && bus.start;
        last       = (state == ST_COMPUTE) && (cnt == CW'(WIDTH - 1));
        bus.busy   = accept || (state == ST_COMPUTE);
        bus.done   = state == ST_DONE;
        bus.result = result_q;
        state_n    = accept ? ST_COMPUTE : last ? ST_DONE : (state == ST_DONE) ? ST_IDLE : state;
        sg1        = (bus.op != MC_MUL) && (bus.op != MC_MULHU) && (bus.op != MC_DIVU) && (bus.op != MC_REMU);
        sg2        = (bus.op == MC_MULH) || (bus.op == MC_DIV) || (bus.op == MC_REM);
        m1         = (sg1 && bus.operand1[WIDTH-1]) ? ~bus.operand1 + 1'b1 : bus.operand1;
        m2         = (sg2 && bus.operand2[WIDTH-1]) ? ~bus.operand2 + 1'b1 : bus.operand2;
        is_div     = op_q[2];
        // divide shifts the next dividend bit into the partial remainder before the trial subtract
        as_a       = is_div ? {hi[WIDTH-1:0], lo[WIDTH-1]} : hi;
        as_b       = {1'b0, opb};
        mul_t      = lo[0] ? as_sum : hi;
        hi_n       = is_div ? (as_cout ? as_sum : as_a) : {1'b0, mul_t[WIDTH:1]};
        lo_n       = is_div ? {lo[WIDTH-2:0], as_cout} : {mul_t[0], lo[WIDTH-1:1]};
        prod       = {hi_n[WIDTH-1:0], lo_n};
        prod_f     = (s1 ^ s2) ? ~prod + 1'b1 : prod;
        quo        = lo_n;
        remd       = hi_n[WIDTH-1:0];
        res_n      = (op_q == MC_MUL) ? prod_f[WIDTH-1:0] :
                     !is_div ? prod_f[2*WIDTH-1:WIDTH] :
                     dz ? (op_q[1] ? orig1 : '1) :
                     op_q[1] ? (s1 ? ~remd + 1'b1 : remd) :
                     ((s1 ^ s2) ? ~quo + 1'b1 : quo);
    end
    mcycle_addsub #(.W(WIDTH + 1)) u_addsub (
        .a(as_a), .b(as_b), .sub(is_div), .sum(as_sum), .cout(as_cout)
    );
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            op_q     <= MC_MUL;
            cnt      <= '0;
            s1       <= 1'b0;
            s2       <= 1'b0;
            dz       <= 1'b0;
            hi       <= '0;
            lo       <= '0;
            opb      <= '0;
            orig1    <= '0;
            result_q <= '0;
        end else begin
            state <= state_n;
            if (accept) begin
                op_q  <= mc_op_e'(bus.op);
                cnt   <= '0;
                s1    <= sg1 && bus.operand1[WIDTH-1];
                s2    <= sg2 && bus.operand2[WIDTH-1];
                dz    <= bus.operand2 == '0;
                orig1 <= bus.operand1;
                hi    <= '0;
                lo    <= bus.op[2] ? m1 : m2;
                opb   <= bus.op[2] ? m2 : m1;
            end else if (state == ST_COMPUTE) begin
                cnt <= cnt + CW'(1);
                hi  <= hi_n;
                lo  <= lo_n;
                if (last) result_q <= res_n;
            end
        end
    end
endmodule

// File: tb/tb_mcycle_unit.sv
// tb_mcycle_unit: directed self-checking bench for the multiply/divide sequencer
module tb_mcycle_unit;
    import mcycle_unit_pkg::*;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int n_cmp = 0;
    int n_err = 0;
    mcycle_unit_if #(.WIDTH(32)) bus ();
    mcycle_unit #(.WIDTH(32)) dut (.clk(clk), .rst(rst), .bus(bus.slave));
    always #5 clk = ~clk;
    task automatic step();
        @(posedge clk);
        #1;
    endtask
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask
    task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp, input string tag);
        int n;
        logic busy_ok;
        bus.op = o;
        bus.operand1 = a;
        bus.operand2 = b;
        bus.start = 1'b1;
        #1;
        chk({tag, "_busy_start"}, 32'(bus.busy), 32'd1);
        step();
        bus.start = 1'b0;
        bus.op = 3'($urandom);
        bus.operand1 = $urandom;
        bus.operand2 = $urandom;
        #1;
        n = 1;
        busy_ok = 1'b1;
        while (!bus.done && n < 40) begin
            busy_ok &= bus.busy;
            step();
            n++;
        end
        chk({tag, "_latency"}, 32'(n), 32'd33);
        chk({tag, "_result"}, bus.result, exp);
        chk({tag, "_busy_compute"}, 32'(busy_ok), 32'd1);
        chk({tag, "_busy_done"}, 32'(bus.busy), 32'd0);
        step();
        chk({tag, "_done_pulse"}, 32'(bus.done), 32'd0);
    endtask
    initial begin
        int c1, c2, dn;
        logic [31:0] r1, r2;
        bus.start = 1'b0;
        bus.op = 3'd0;
        bus.operand1 = '0;
        bus.operand2 = '0;
        step();
        step();
        chk("rst_result", bus.result, 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_busy_idle", 32'(bus.busy), 32'd0);
        bus.start = 1'b1;
        #1;
        chk("rst_busy_start", 32'(bus.busy), 32'd1);
        step();
        chk("rst_no_done", 32'(bus.done), 32'd0);
        bus.start = 1'b0;
        rst = 1'b0;
        step();
        run_op(MC_MUL,    32'd7,        32'hFFFF_FFFD, 32'hFFFF_FFEB, "mul");
        run_op(MC_MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000, "mulh");
        run_op(MC_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, "mulhu");
        run_op(MC_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mulhsu");
        run_op(MC_DIV,    32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFD, "div");
        run_op(MC_REM,    32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, "rem");
        run_op(MC_DIVU,   32'd100,      32'd7,        32'd14,        "divu");
        run_op(MC_REMU,   32'd100,      32'd7,        32'd2,         "remu");
        run_op(MC_DIV,    32'h1234_5678, 32'd0,        32'hFFFF_FFFF, "div0");
        run_op(MC_DIVU,   32'h1234_5678, 32'd0,        32'hFFFF_FFFF, "divu0");
        run_op(MC_REM,    32'h1234_5678, 32'd0,        32'h1234_5678, "rem0");
        run_op(MC_REMU,   32'h1234_5678, 32'd0,        32'h1234_5678, "remu0");
        run_op(MC_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, "div_ovf");
        run_op(MC_REM,    32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         "rem_ovf");
        // Start held for 40 cycles with operands moving every cycle
        c1 = -1;
        c2 = -1;
        dn = 0;
        r1 = '0;
        r2 = '0;
        for (int k = 0; k < 90; k++) begin
            bus.start = k < 40;
            bus.op = MC_MUL;
            bus.operand1 = 32'(1000 + 17 * k);
            bus.operand2 = 32'(3 + k);
            #1;
            if (k == 33) chk("hold_busy_done_cycle", 32'(bus.busy), 32'd1);
            if (bus.done) begin
                dn++;
                if (c1 < 0) begin
                    c1 = k;
                    r1 = bus.result;
                end else begin
                    c2 = k;
                    r2 = bus.result;
                end
            end
            step();
        end
        chk("hold_done_count", 32'(dn), 32'd2);
        chk("hold_first_cycle", 32'(c1), 32'd33);
        chk("hold_first_result", r1, 32'd3000);
        chk("hold_second_cycle", 32'(c2), 32'd66);
        chk("hold_second_result", r2, 32'd56196);
        // reset in the middle of an operation
        bus.op = MC_MUL;
        bus.operand1 = 32'h1234;
        bus.operand2 = 32'h10;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        for (int k = 1; k < 10; k++) step();
        chk("abort_busy_c10", 32'(bus.busy), 32'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
        chk("abort_result", bus.result, 32'd0);
        chk("abort_done", 32'(bus.done), 32'd0);
        chk("abort_busy", 32'(bus.busy), 32'd0);
        dn = 0;
        for (int k = 0; k < 40; k++) begin
            if (bus.done) dn++;
            step();
        end
        chk("abort_no_done", 32'(dn), 32'd0);
        run_op(MC_MUL, 32'd3, 32'd5, 32'd15, "mul_after_rst");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
